// File: rtl/series_datapath.sv
// series_datapath: datapath for the truncated exponential series
//   r = sum_{n=0..TERMS} x^n / n!   (unsigned fixed point, 1.0 = 2^FRAC)
// Driven cycle by cycle by the series controller through load/select strobes.
// Optional feature macro: SERIES_SAT_EN
//   defined   -> multiplier and adder overflow clamp to all ones
//   undefined -> multiplier keeps the truncated slice, adder wraps
module series_datapath #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int TERMS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x_in,
  input  logic             x_ld,
  input  logic             t_init,
  input  logic             t_ld,
  input  logic             r_init,
  input  logic             r_ld,
  input  logic             cnt_set,
  input  logic             cnt_en,
  input  logic             mux_sel,
  output logic             y_bigger,
  output logic [WIDTH-1:0] result
);

  localparam int NW = $clog2(TERMS + 2);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   t_q, t_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [NW-1:0]      n_q, n_d;

  logic [WIDTH-1:0]   lut_val;
  logic [WIDTH-1:0]   mul_op;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   prod_fx;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   sum_fx;
  logic               unused_bits;

  // Reciprocal table: round(2^FRAC / n), ties up; 1.0 at n=0, zero past TERMS.
  function automatic logic [WIDTH-1:0] recip(input logic [NW-1:0] n);
    int ni;
    ni = int'(n);
    if (ni == 0)
      return ONE;
    else if (ni <= TERMS)
      return WIDTH'((2 ** (FRAC + 1) + ni) / (2 * ni));
    else
      return '0;
  endfunction

  // Reduce the full product to the Q format, clamping when high bits are lost.
  function automatic logic [WIDTH-1:0] mul_fix(input logic [2*WIDTH-1:0] p);
`ifdef SERIES_SAT_EN
    if (|p[2*WIDTH-1:FRAC+WIDTH])
      return '1;
`endif
    return p[FRAC+WIDTH-1:FRAC];
  endfunction

  // Reduce the widened sum, clamping on carry-out when saturation is built in.
  function automatic logic [WIDTH-1:0] add_fix(input logic [WIDTH:0] s);
`ifdef SERIES_SAT_EN
    if (s[WIDTH])
      return '1;
`endif
    return s[WIDTH-1:0];
  endfunction

  assign lut_val = recip(n_q);
  assign mul_op  = mux_sel ? lut_val : x_q;
  assign prod    = {{WIDTH{1'b0}}, t_q} * {{WIDTH{1'b0}}, mul_op};
  assign prod_fx = mul_fix(prod);
  assign sum     = {1'b0, r_q} + {1'b0, t_q};
  assign sum_fx  = add_fix(sum);

  // Fraction bits and overflow bits are only consumed in some build variants.
  assign unused_bits = ^{prod[FRAC-1:0], prod[2*WIDTH-1:FRAC+WIDTH], sum[WIDTH]};

  // Termination flag looks at the count before any increment this cycle.
  assign y_bigger = (int'(n_q) >= TERMS);
  assign result   = r_q;

  // Next-state selection; init/set strobes take priority over load/enable.
  always_comb begin
    x_d = x_q;
    t_d = t_q;
    r_d = r_q;
    n_d = n_q;
    if (x_ld)
      x_d = x_in;
    if (t_init)
      t_d = ONE;
    else if (t_ld)
      t_d = prod_fx;
    if (r_init)
      r_d = ONE;
    else if (r_ld)
      r_d = sum_fx;
    if (cnt_set)
      n_d = NW'(1);
    else if (cnt_en)
      n_d = n_q + NW'(1);
  end

  // State registers with asynchronous clear of every register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      t_q <= '0;
      r_q <= '0;
      n_q <= '0;
    end else begin
      x_q <= x_d;
      t_q <= t_d;
      r_q <= r_d;
      n_q <= n_d;
    end
  end

endmodule
